mesh_conv_seq: RTL and testbench
================================

// Module: mesh_conv_seq
// PURPOSE
//  Job sequencer for a MESH_ROWS x MESH_COLS mesh of convolution cells. Streams window weights
//  (broadcast to all cells) and per-cell pixel values from a cfg stream. Launches the mesh with a
//  one-cycle active-low cell reset, then waits out the fixed Hamiltonian-path run time. Reads each
//  cell's conv result through a row/col mux and emits them row-major on a valid/ready stream.
// PARAMETERS
//  WIN_WIDTH   5   window width (>2)
//  WIN_HEIGHT  6   window height (even)
//  MESH_ROWS   4   cell rows
//  MESH_COLS   4   cell cols
//  DW          12  result width
//  VW          4   weight/pixel width
// PORTS
//  ck          in   1         clock, rising edge
//  res         in   1         async reset, active-low
//  start       in   1         begin job; honoured only in IDLE
//  busy        out  1         high in every state but IDLE
//  done        out  1         1-cycle pulse after last result accepted
//  cfg_valid   in   1         cfg beat valid
//  cfg_ready   out  1         high only in LOAD_W / LOAD_PX
//  cfg_data    in   VW        weight (LOAD_W) or pixel (LOAD_PX)
//  w_we        out  1         weight write strobe, broadcast to all cells
//  w_addr      out  5         weight index 0..WIN_WIDTH*WIN_HEIGHT-1
//  w_data      out  VW        weight value
//  px_we       out  1         pixel write strobe
//  px_row/col  out  2/2       target cell (log2 of mesh dims)
//  px_data     out  VW        pixel value
//  cell_res_n  out  1         mesh reset/launch, active-low
//  rd_row/col  out  2/2       result mux select
//  rd_data     in   DW        conv of selected cell, combinational from rd_row/col
//  res_valid   out  1         result beat valid
//  res_ready   in   1         result beat accepted
//  res_data    out  DW        result value
//  res_last    out  1         high with final beat (cell MESH_ROWS-1,MESH_COLS-1)
// BEHAVIOUR
//  Reset (res=0, async): state=IDLE; all counters 0; busy, done, cfg_ready, w_we, px_we, res_valid, res_last = 0;
//   cell_res_n=1; w_addr, px_row/col, rd_row/col, w_data, px_data, res_data = 0.
//   Reset mid-job abandons it; no done is produced.
//  FSM: IDLE -> LOAD_W -> LOAD_PX -> LAUNCH -> RUN -> FETCH -> OUT -> (FETCH | DONE) -> IDLE.
//  IDLE: start=1 -> LOAD_W next cycle; start in any other state is ignored (no queueing).
//  LOAD_W: each cfg_valid&cfg_ready cycle registers w_we=1, w_addr=count, w_data=cfg_data (1-cycle latency).
//   After beat WIN_WIDTH*WIN_HEIGHT-1 (29) is accepted -> LOAD_PX. cfg_valid gaps stall without penalty.
//  LOAD_PX: same rule, px_row/col advance row-major from (0,0); 16th beat -> LAUNCH.
//  LAUNCH: cell_res_n=0 for exactly 1 cycle, then 1 -> RUN.
//  RUN: counter of RUN_CYC = 2*WIN_WIDTH*WIN_HEIGHT+2 (62) cycles, counting from the first cycle
//   with cell_res_n=1 (1 initiate cycle, 2 per path step, 1 margin) -> FETCH with rd_row/col=(0,0).
//  FETCH: 1 cycle; res_data <= rd_data; res_valid <= 1; res_last set for final cell -> OUT.
//  OUT: res_data/res_last held stable while res_valid & !res_ready. On handshake: res_valid=0.
//   If not last, advance rd_row/col row-major (col wraps MESH_COLS-1 -> 0 with row+1) -> FETCH.
//   If last -> DONE.
//  DONE: done=1 one cycle, busy=0 next cycle -> IDLE.
//  Throughput: one result per 2 cycles with res_ready held high.
//  Widths: counters sized for max count; no arithmetic on data, values pass unchanged.
//  cfg_ready=0 outside load states; cfg beats offered then are not consumed.
// TESTING
//  1. Assert res=0 mid-cycle -> all outputs at reset values immediately; cell_res_n=1.
//  2. start, 30 weights=10, 16 pixels=5, uniform mesh model -> w_we x30 (addr 0..29), px_we x16,
//     one cell_res_n=0 pulse, 62 RUN cycles, 16 beats of 1500, res_last on beat 16, done pulse.
//  3. cfg_valid toggled every other cycle -> identical w/px writes, load phase twice as long.
//  4. res_ready low 5 cycles on beat 3 -> res_data/res_last stable, no beat lost or repeated.
//  5. start pulsed during LOAD_PX and RUN -> ignored; job completes once with single done.
//  6. res=0 in RUN cycle 20, then new start -> fresh LOAD_W from w_addr 0; no stale done/res_valid.

Source files
------------

// File: rtl/mesh_conv_seq.sv
// Job sequencer for a mesh of convolution cells: loads broadcast weights and per-cell pixels,
// launches the mesh, waits out the path run time, then streams each cell's result row-major.
module mesh_conv_seq #(
  parameter  int WIN_WIDTH  = 5,
  parameter  int WIN_HEIGHT = 6,
  parameter  int MESH_ROWS  = 4,
  parameter  int MESH_COLS  = 4,
  parameter  int DW         = 12,
  parameter  int VW         = 4,
  localparam int AW         = $clog2(WIN_WIDTH * WIN_HEIGHT),
  localparam int RW         = $clog2(MESH_ROWS),
  localparam int CW         = $clog2(MESH_COLS)
) (
  input  logic          ck,
  input  logic          res,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [VW-1:0] cfg_data,
  output logic          w_we,
  output logic [AW-1:0] w_addr,
  output logic [VW-1:0] w_data,
  output logic          px_we,
  output logic [RW-1:0] px_row,
  output logic [CW-1:0] px_col,
  output logic [VW-1:0] px_data,
  output logic          cell_res_n,
  output logic [RW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  input  logic [DW-1:0] rd_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_last,
  output logic [2:0]    state_dbg
);

  // Handshakes: a cfg beat transfers on a rising edge where cfg_valid && cfg_ready; a result beat
  // transfers where res_valid && res_ready. Once res_valid rises, res_data/res_last hold until taken.

  localparam int NW      = WIN_WIDTH * WIN_HEIGHT;
  localparam int RUN_CYC = 2 * NW + 2;
  localparam int RCW     = $clog2(RUN_CYC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_PX = 3'd2,
    S_LAUNCH  = 3'd3,
    S_RUN     = 3'd4,
    S_FETCH   = 3'd5,
    S_OUT     = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t         state;
  logic [AW-1:0]  w_cnt;
  logic [RW-1:0]  ld_row;
  logic [CW-1:0]  ld_col;
  logic [RCW-1:0] run_cnt;

  assign state_dbg = state;

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state      <= S_IDLE;
      w_cnt      <= '0;
      ld_row     <= '0;
      ld_col     <= '0;
      run_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_ready  <= 1'b0;
      w_we       <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      px_we      <= 1'b0;
      px_row     <= '0;
      px_col     <= '0;
      px_data    <= '0;
      cell_res_n <= 1'b1;
      rd_row     <= '0;
      rd_col     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_last   <= 1'b0;
    end else begin
      w_we  <= 1'b0;
      px_we <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD_W;
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
            w_cnt     <= '0;
            ld_row    <= '0;
            ld_col    <= '0;
            run_cnt   <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
          end
        end
        S_LOAD_W: begin
          if (cfg_valid && cfg_ready) begin
            w_we   <= 1'b1;
            w_addr <= w_cnt;
            w_data <= cfg_data;
            if (w_cnt == AW'(NW - 1)) begin
              w_cnt <= '0;
              state <= S_LOAD_PX;
            end else begin
              w_cnt <= w_cnt + AW'(1);
            end
          end
        end
        S_LOAD_PX: begin
          if (cfg_valid && cfg_ready) begin
            px_we   <= 1'b1;
            px_row  <= ld_row;
            px_col  <= ld_col;
            px_data <= cfg_data;
            if (ld_col == CW'(MESH_COLS - 1)) begin
              ld_col <= '0;
              if (ld_row == RW'(MESH_ROWS - 1)) begin
                ld_row     <= '0;
                cfg_ready  <= 1'b0;
                cell_res_n <= 1'b0;
                state      <= S_LAUNCH;
              end else begin
                ld_row <= ld_row + RW'(1);
              end
            end else begin
              ld_col <= ld_col + CW'(1);
            end
          end
        end
        S_LAUNCH: begin
          cell_res_n <= 1'b1;
          run_cnt    <= '0;
          state      <= S_RUN;
        end
        S_RUN: begin
          // Counts every cycle with the mesh released, starting with the first one.
          if (run_cnt == RCW'(RUN_CYC - 1)) begin
            run_cnt <= '0;
            rd_row  <= '0;
            rd_col  <= '0;
            state   <= S_FETCH;
          end else begin
            run_cnt <= run_cnt + RCW'(1);
          end
        end
        S_FETCH: begin
          res_data  <= rd_data;
          res_valid <= 1'b1;
          res_last  <= (rd_row == RW'(MESH_ROWS - 1)) && (rd_col == CW'(MESH_COLS - 1));
          state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            if (res_last) begin
              rd_row <= '0;
              rd_col <= '0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              if (rd_col == CW'(MESH_COLS - 1)) begin
                rd_col <= '0;
                rd_row <= rd_row + RW'(1);
              end else begin
                rd_col <= rd_col + CW'(1);
              end
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_conv_seq.sv
// Bench for mesh_conv_seq: drives cfg jobs, models the mesh result mux, and scoreboards the
// weight/pixel writes and the result stream against values derived from the driven stimulus.
module tb_mesh_conv_seq;

  localparam int NW       = 30;
  localparam int NP       = 16;
  localparam int MESH_COLS = 4;
  localparam int AW = 5, RW = 2, CW = 2, DW = 12, VW = 4;
  localparam int CFG_TO  = 200;
  localparam int RUN_GAP = 63;

  // clock / reset
  logic ck = 1'b0;
  logic res;
  always #5 ck = ~ck;

  logic          start, busy, done, cfg_valid, cfg_ready;
  logic [VW-1:0] cfg_data, w_data, px_data;
  logic          w_we, px_we, cell_res_n, res_valid, res_ready, res_last;
  logic [AW-1:0] w_addr;
  logic [RW-1:0] px_row, rd_row;
  logic [CW-1:0] px_col, rd_col;
  logic [DW-1:0] rd_data, res_data;
  logic [2:0]    state_dbg;

  mesh_conv_seq dut (
    .ck(ck), .res(res), .start(start), .busy(busy), .done(done),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .px_we(px_we), .px_row(px_row), .px_col(px_col), .px_data(px_data),
    .cell_res_n(cell_res_n), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .state_dbg(state_dbg)
  );

  // scoreboard state
  logic [AW+VW-1:0]    exp_w_q[$];
  logic [RW+CW+VW-1:0] exp_px_q[$];
  logic [DW:0]         exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int beats_acc, done_cnt, launch_cnt, gap_cnt;
  bit gap_active, prev_stall, prev_last, prev_done, launched;
  logic [DW-1:0] prev_data;

  // mesh model: each cell reports (sum of written weights) * (its written pixel) once launched
  logic [VW-1:0] mw [32];
  logic [VW-1:0] mpx[16];

  always_comb begin
    int acc;
    acc = 0;
    for (int a = 0; a < NW; a++) acc = acc + int'(mw[a]);
    rd_data = launched ? DW'(acc * int'(mpx[{rd_row, rd_col}])) : DW'(12'hBAD);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // monitor: samples 2 time units after the falling edge, after the drivers have settled
  always begin
    logic [AW+VW-1:0]    ew;
    logic [RW+CW+VW-1:0] ep;
    logic [DW:0]         er;
    @(negedge ck);
    #2;
    if (!res) begin
      launched   = 1'b0;
      gap_active = 1'b0;
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (w_we) begin
        check("w_expected", 32'(exp_w_q.size() != 0), 32'd1);
        if (exp_w_q.size() != 0) begin
          ew = exp_w_q.pop_front();
          check("w_addr", 32'(w_addr), 32'(ew[AW+VW-1:VW]));
          check("w_data", 32'(w_data), 32'(ew[VW-1:0]));
        end
        mw[w_addr] = w_data;
      end
      if (px_we) begin
        check("px_expected", 32'(exp_px_q.size() != 0), 32'd1);
        if (exp_px_q.size() != 0) begin
          ep = exp_px_q.pop_front();
          check("px_cell", 32'({px_row, px_col}), 32'(ep[RW+CW+VW-1:VW]));
          check("px_data", 32'(px_data), 32'(ep[VW-1:0]));
        end
        mpx[{px_row, px_col}] = px_data;
      end
      if (!busy) launched = 1'b0;
      if (!cell_res_n) begin
        launch_cnt++;
        launched   = 1'b1;
        gap_active = 1'b1;
        gap_cnt    = 0;
      end else if (gap_active) begin
        if (res_valid) begin
          check("run_gap", 32'(gap_cnt), 32'(RUN_GAP));
          gap_active = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (prev_stall) begin
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_data", 32'(res_data), 32'(prev_data));
        check("hold_last", 32'(res_last), 32'(prev_last));
      end
      if (res_valid && res_ready) begin
        check("res_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          er = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(er[DW-1:0]));
          check("res_last", 32'(res_last), 32'(er[DW]));
        end
        beats_acc++;
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
      prev_last  = res_last;
      if (done) begin
        done_cnt++;
        check("done_width", 32'(prev_done), 32'd0);
      end
      prev_done = done;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
    check({tag, "_w_we"}, 32'(w_we), 32'd0);
    check({tag, "_px_we"}, 32'(px_we), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_last"}, 32'(res_last), 32'd0);
    check({tag, "_cell_res_n"}, 32'(cell_res_n), 32'd1);
    check({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    check({tag, "_w_data"}, 32'(w_data), 32'd0);
    check({tag, "_px_cell"}, 32'({px_row, px_col}), 32'd0);
    check({tag, "_px_data"}, 32'(px_data), 32'd0);
    check({tag, "_rd_cell"}, 32'({rd_row, rd_col}), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // driver tasks: all called at a falling edge and return at a falling edge
  task automatic mid_cycle_reset(input string tag);
    #3 res = 1'b0;
    #1 check_reset_outputs(tag);
    repeat (2) @(negedge ck);
    res = 1'b1;
    exp_w_q.delete();
    exp_px_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_job_stats();
    beats_acc  = 0;
    done_cnt   = 0;
    launch_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [VW-1:0] d, input bit gap, output int cyc);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && n < CFG_TO) begin
      @(negedge ck);
      n++;
    end
    if (n >= CFG_TO) check("cfg_ready_timeout", 32'(n), 32'd0);
    @(negedge ck);
    cyc = n + 1;
    cfg_valid = 1'b0;
    if (gap) begin
      @(negedge ck);
      cyc++;
    end
  endtask

  task automatic send_weights(input bit rnd, input bit gap, input int count,
                              output int sumw, output int cycles);
    logic [VW-1:0] w;
    int c;
    sumw = 0;
    cycles = 0;
    for (int i = 0; i < count; i++) begin
      w = rnd ? VW'($urandom_range(0, 15)) : VW'(10);
      sumw += int'(w);
      exp_w_q.push_back({AW'(i), w});
      send_beat(w, gap, c);
      cycles += c;
    end
  endtask

  task automatic load_job(input bit rnd, input bit gap, input bit start_mid, output int cycles);
    logic [VW-1:0] p;
    int sumw, c;
    send_weights(rnd, gap, NW, sumw, cycles);
    for (int i = 0; i < NP; i++) begin
      p = rnd ? VW'($urandom_range(0, 15)) : VW'(5);
      exp_px_q.push_back({RW'(i / MESH_COLS), CW'(i % MESH_COLS), p});
      exp_q.push_back({(i == NP - 1), DW'(sumw * int'(p))});
      if (start_mid && i == 5) start = 1'b1;
      send_beat(p, gap, c);
      start = 1'b0;
      cycles += c;
    end
  endtask

  task automatic collect(input bit stall, input bit start_run);
    int stall_cnt;
    bit stall_used;
    stall_cnt  = 0;
    stall_used = 1'b0;
    res_ready  = 1'b1;
    for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
      @(negedge ck);
      if (start_run) start = (cyc == 10);
      if (stall) begin
        if (!stall_used && beats_acc == 2) begin
          res_ready  = 1'b0;
          stall_cnt  = 5;
          stall_used = 1'b1;
        end else if (stall_cnt > 0) begin
          stall_cnt--;
          if (stall_cnt == 0) res_ready = 1'b1;
        end
      end
    end
    start     = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge ck);
    check("job_done_cnt", 32'(done_cnt), 32'd1);
    check("job_beats", 32'(beats_acc), 32'(NP));
    check("job_launches", 32'(launch_cnt), 32'd1);
    check("job_res_left", 32'(exp_q.size()), 32'd0);
    check("job_w_left", 32'(exp_w_q.size()), 32'd0);
    check("job_px_left", 32'(exp_px_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_state", 32'(state_dbg), 32'd0);
  endtask

  task automatic run_job(input bit rnd, input bit gap, input bit stall, input bit start_mid,
                         input int exp_load_cycles);
    int cycles;
    clear_job_stats();
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_cfg_ready", 32'(cfg_ready), 32'd1);
    load_job(rnd, gap, start_mid, cycles);
    check("load_cycles", 32'(cycles), 32'(exp_load_cycles));
    collect(stall, start_mid);
  endtask

  initial begin
    int sumw, cycles;
    res       = 1'b0;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge ck);
    check_reset_outputs("por");
    res = 1'b1;
    @(negedge ck);

    // abandon a job in the middle of the weight load
    clear_job_stats();
    do_start();
    send_weights(1'b1, 1'b0, 7, sumw, cycles);
    mid_cycle_reset("rst_load");
    repeat (3) @(negedge ck);
    check("rst_load_no_done", 32'(done_cnt), 32'd0);

    run_job(1'b0, 1'b0, 1'b0, 1'b0, NW + NP);        // uniform 10/5 -> 1500 per cell
    run_job(1'b1, 1'b1, 1'b0, 1'b0, 2 * (NW + NP));  // cfg_valid gaps
    run_job(1'b1, 1'b0, 1'b1, 1'b0, NW + NP);        // result back-pressure on beat 3
    run_job(1'b0, 1'b0, 1'b0, 1'b1, NW + NP);        // stray start pulses
    repeat (10) @(negedge ck);
    check("no_queued_busy", 32'(busy), 32'd0);
    check("no_queued_done", 32'(done_cnt), 32'd1);

    // reset in RUN cycle 20, then a fresh job
    clear_job_stats();
    do_start();
    load_job(1'b1, 1'b0, 1'b0, cycles);
    repeat (20) @(negedge ck);
    check("run20_state", 32'(state_dbg), 32'd4);
    mid_cycle_reset("rst_run");
    repeat (5) begin
      @(negedge ck);
      check("rst_run_res_valid", 32'(res_valid), 32'd0);
    end
    check("rst_run_no_done", 32'(done_cnt), 32'd0);
    run_job(1'b1, 1'b0, 1'b0, 1'b0, NW + NP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
